// File: rtl/bm_frame_scheduler_if.sv
// bm_frame_scheduler_if: frame control, matcher handshake and address bus of the frame scheduler (frame_cycles only with BM_SCHED_CYCLE_CNT_EN)
interface bm_frame_scheduler_if;
  logic frame_start, frame_abort, dn_ready, bm_done, bm_start, frame_busy, frame_done, sched_err;
  logic [15:0] blk_base, srch_base, blk_start_address, srch_start_address, blk_index;
`ifdef BM_SCHED_CYCLE_CNT_EN
  logic [31:0] frame_cycles;
`endif
  modport master (
    input frame_start, frame_abort, blk_base, srch_base, dn_ready, bm_done,
`ifdef BM_SCHED_CYCLE_CNT_EN
    output frame_cycles,
`endif
    output bm_start, blk_start_address, srch_start_address, blk_index, frame_busy, frame_done, sched_err
  );
  modport slave (
    output frame_start, frame_abort, blk_base, srch_base, dn_ready, bm_done,
`ifdef BM_SCHED_CYCLE_CNT_EN
    input frame_cycles,
`endif
    input bm_start, blk_start_address, srch_start_address, blk_index, frame_busy, frame_done, sched_err
  );
endinterface

// File: rtl/bm_frame_scheduler.sv
// bm_frame_scheduler: raster-order block sequencer with clamped search window; BM_SCHED_CYCLE_CNT_EN adds frame_cycles
module bm_frame_scheduler #(
  parameter int rd_port_w    = 8,
  parameter int block_size   = 16,
  parameter int search_blk_w = 64,
  parameter int search_blk_h = 32,
  parameter int line_w       = 128,
  parameter int frame_h      = 64,
  parameter int ack_timeout  = 8
) (
  input logic clk,
  input logic reset_n,
  bm_frame_scheduler_if.master bus
);
  localparam int law = line_w / rd_port_w;
  localparam int bpr = line_w / block_size;
  localparam int bpc = frame_h / block_size;
  localparam int mx  = (search_blk_w - block_size) / 2;
  localparam int my  = (search_blk_h - block_size) / 2;
  localparam int cw  = $clog2(ack_timeout + 1);
  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE, NEXT} state_t;
  state_t state_q, state_d;
  logic [15:0] bx_q, bx_d, by_q, by_d, blk_base_q, blk_base_d, srch_base_q, srch_base_d;
  logic [15:0] blk_addr_q, blk_addr_d, srch_addr_q, srch_addr_d, idx_q, idx_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, abort_q, abort_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic start, fin, ab, last;
  int sxr, syr, sx, sy;
  // next state, block walk and address computation; an abort seen while the matcher runs is held until it goes idle
  always_comb begin
    state_d = state_q;
    bx_d = bx_q;
    by_d = by_q;
    blk_base_d = blk_base_q;
    srch_base_d = srch_base_q;
    blk_addr_d = blk_addr_q;
    srch_addr_d = srch_addr_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    abort_d = abort_q;
    cnt_d = cnt_q;
    start = 1'b0;
    fin = 1'b0;
    ab = bus.frame_abort || abort_q;
    last = bx_q == 16'(bpr - 1) && by_q == 16'(bpc - 1);
    sxr = int'(bx_q) * block_size - mx;
    syr = int'(by_q) * block_size - my;
    sx = sxr < 0 ? 0 : (sxr > line_w - search_blk_w ? line_w - search_blk_w : sxr);
    sy = syr < 0 ? 0 : (syr > frame_h - search_blk_h ? frame_h - search_blk_h : syr);
    case (state_q)
      IDLE: if (bus.frame_start) begin
        blk_base_d = bus.blk_base;
        srch_base_d = bus.srch_base;
        bx_d = '0;
        by_d = '0;
        err_d = 1'b0;
        abort_d = 1'b0;
        busy_d = 1'b1;
        state_d = CALC;
      end
      CALC: if (ab) fin = 1'b1;
      else begin
        blk_addr_d = blk_base_q + 16'(int'(by_q) * block_size * law + int'(bx_q) * (block_size / rd_port_w));
        srch_addr_d = srch_base_q + 16'(sy * law + sx / rd_port_w);
        idx_d = 16'(int'(by_q) * bpr + int'(bx_q));
        state_d = ISSUE;
      end
      ISSUE: if (ab) fin = 1'b1;
      else if (bus.dn_ready && bus.bm_done) begin
        start = 1'b1;
        cnt_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        abort_d = ab;
        if (!bus.bm_done) state_d = WAIT_DONE;
        else if (cnt_q == cw'(ack_timeout - 1)) begin
          err_d = 1'b1;
          fin = ab;
          state_d = NEXT;
        end else cnt_d = cnt_q + cw'(1);
      end
      WAIT_DONE: begin
        abort_d = ab;
        if (bus.bm_done) begin
          fin = ab;
          state_d = NEXT;
        end
      end
      NEXT: begin
        fin = ab || last;
        bx_d = bx_q == 16'(bpr - 1) ? '0 : bx_q + 16'd1;
        by_d = bx_q == 16'(bpr - 1) ? by_q + 16'd1 : by_q;
        state_d = CALC;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = IDLE;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bx_q <= '0;
      by_q <= '0;
      blk_base_q <= '0;
      srch_base_q <= '0;
      blk_addr_q <= '0;
      srch_addr_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      abort_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      bx_q <= bx_d;
      by_q <= by_d;
      blk_base_q <= blk_base_d;
      srch_base_q <= srch_base_d;
      blk_addr_q <= blk_addr_d;
      srch_addr_q <= srch_addr_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      abort_q <= abort_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.bm_start = start && reset_n;
  assign bus.blk_start_address = blk_addr_q;
  assign bus.srch_start_address = srch_addr_q;
  assign bus.blk_index = idx_q;
  assign bus.frame_busy = busy_q;
  assign bus.frame_done = done_q;
  assign bus.sched_err = err_q;
`ifdef BM_SCHED_CYCLE_CNT_EN
  logic [31:0] cyc_q;
  // busy-cycle counter, saturating, restarted when a frame is accepted
  always_ff @(posedge clk) begin
    if (!reset_n) cyc_q <= '0;
    else if (state_q == IDLE && bus.frame_start) cyc_q <= '0;
    else if (busy_q && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
  end
  assign bus.frame_cycles = cyc_q;
`endif
endmodule

// File: tb/tb_bm_frame_scheduler.sv
// tb_bm_frame_scheduler: directed table and sequence checks of bm_frame_scheduler against a simple matcher model
module tb_bm_frame_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bm_frame_scheduler_if bus();
  bm_frame_scheduler dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int bx;
    int by;
    logic [15:0] blk;
    logic [15:0] srch;
    logic [15:0] idx;
  } vec_t;
  vec_t vecs [8];
  int n_chk = 0, n_err = 0;
  int n_start, n_done, n_ack, mdl_cnt, hang_idx = -1;
  bit pend, mdl_rst = 1'b1;
  int idx_log [$];
  logic [15:0] blk_log [32];
  logic [15:0] srch_log [32];
  // matcher model: drops bm_done the cycle after a start, raises it 20 cycles later; hang_idx never acknowledges
  always @(negedge clk) begin
    bit st;
    st = bus.bm_start;
    if (mdl_rst) begin
      pend = 0;
      mdl_cnt = 0;
      bus.bm_done = 1'b1;
      n_start = 0;
      n_done = 0;
      n_ack = 0;
      idx_log.delete();
    end else begin
      if (pend) begin
        pend = 0;
        bus.bm_done = 1'b0;
        mdl_cnt = 20;
        n_ack++;
      end else if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) bus.bm_done = 1'b1;
      end
      if (st) begin
        n_start++;
        idx_log.push_back(int'(bus.blk_index));
        blk_log[bus.blk_index[4:0]] = bus.blk_start_address;
        srch_log[bus.blk_index[4:0]] = bus.srch_start_address;
        if (int'(bus.blk_index) != hang_idx) pend = 1;
      end
      if (bus.frame_done) n_done++;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame(input logic [15:0] bb, input logic [15:0] sb);
    mdl_rst = 1'b1;
    tick;
    mdl_rst = 1'b0;
    bus.blk_base = bb;
    bus.srch_base = sb;
    bus.frame_start = 1'b1;
    tick;
    bus.frame_start = 1'b0;
  endtask
  task automatic wait_starts(input int n);
    int k = 0;
    while (n_start < n && k < 3000) begin
      tick;
      k++;
    end
    chk("wait_starts", 32'(n_start >= n), 1);
  endtask
  task automatic wait_done;
    int k = 0;
    while (n_done == 0 && k < 3000) begin
      tick;
      k++;
    end
    chk("wait_frame_done", 32'(n_done), 1);
  endtask
  task automatic wait_bm_low;
    int k = 0;
    while (bus.bm_done !== 1'b0 && k < 50) begin
      tick;
      k++;
    end
    chk("bm_done_low", 32'(bus.bm_done), 0);
  endtask
  initial begin
    int k, bad;
    vecs = '{'{0, 0, 16'd0, 16'd0, 16'd0}, '{1, 0, 16'd2, 16'd0, 16'd1},
             '{2, 0, 16'd4, 16'd1, 16'd2}, '{6, 0, 16'd12, 16'd8, 16'd6},
             '{3, 1, 16'd262, 16'd131, 16'd11}, '{5, 2, 16'd522, 16'd391, 16'd21},
             '{0, 3, 16'd768, 16'd512, 16'd24}, '{7, 3, 16'd782, 16'd520, 16'd31}};
    bus.frame_start = 1'b0;
    bus.frame_abort = 1'b0;
    bus.dn_ready = 1'b1;
    bus.blk_base = '0;
    bus.srch_base = '0;
    repeat (3) tick;
    chk("rst_bm_start", 32'(bus.bm_start), 0);
    chk("rst_busy", 32'(bus.frame_busy), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_err", 32'(bus.sched_err), 0);
    chk("rst_idx", 32'(bus.blk_index), 0);
    chk("rst_blk", 32'(bus.blk_start_address), 0);
    chk("rst_srch", 32'(bus.srch_start_address), 0);
    reset_n = 1'b1;
    tick;
    // full frame: latency, issue order and address table
    start_frame(16'd0, 16'd0);
    chk("calc_busy", 32'(bus.frame_busy), 1);
    chk("calc_no_start", 32'(bus.bm_start), 0);
    tick;
    chk("latency_start", 32'(bus.bm_start), 1);
    wait_done;
    chk("f1_starts", 32'(n_start), 32);
    chk("f1_busy_end", 32'(bus.frame_busy), 0);
    chk("f1_err", 32'(bus.sched_err), 0);
    chk("f1_log_len", 32'(idx_log.size()), 32);
    for (int i = 0; i < 32; i++) chk("f1_idx_seq", 32'(idx_log[i]), 32'(i));
    for (int i = 0; i < 8; i++) begin
      chk("tbl_idx", 32'(idx_log[vecs[i].by * 8 + vecs[i].bx]), 32'(vecs[i].idx));
      chk("tbl_blk", 32'(blk_log[vecs[i].idx[4:0]]), 32'(vecs[i].blk));
      chk("tbl_srch", 32'(srch_log[vecs[i].idx[4:0]]), 32'(vecs[i].srch));
    end
    // downstream back-pressure on block 5
    start_frame(16'd0, 16'd0);
    wait_starts(5);
    bus.dn_ready = 1'b0;
    k = 0;
    while (bus.blk_index !== 16'd5 && k < 200) begin
      tick;
      k++;
    end
    chk("hold_reach_blk5", 32'(bus.blk_index), 5);
    bad = 0;
    repeat (50) begin
      if (bus.bm_start !== 1'b0 || bus.blk_start_address !== 16'd10 || bus.srch_start_address !== 16'd7 || bus.blk_index !== 16'd5) bad++;
      tick;
    end
    chk("hold_bad_cycles", 32'(bad), 0);
    chk("hold_starts", 32'(n_start), 5);
    bus.dn_ready = 1'b1;
    #1;
    chk("hold_release_start", 32'(bus.bm_start), 1);
    tick;
    chk("hold_release_count", 32'(n_start), 6);
    wait_done;
    chk("f2_starts", 32'(n_start), 32);
    // block 2 never acknowledged: timeout after 8 cycles, block skipped
    hang_idx = 2;
    start_frame(16'd0, 16'd0);
    wait_starts(3);
    repeat (7) tick;
    chk("to_err_early", 32'(bus.sched_err), 0);
    tick;
    chk("to_err_set", 32'(bus.sched_err), 1);
    wait_done;
    hang_idx = -1;
    chk("to_starts", 32'(n_start), 32);
    chk("to_acks", 32'(n_ack), 31);
    chk("to_next_idx", 32'(idx_log[3]), 3);
    chk("to_err_sticky", 32'(bus.sched_err), 1);
    // abort during WAIT_DONE of block 10
    start_frame(16'd0, 16'd0);
    chk("err_cleared", 32'(bus.sched_err), 0);
    wait_starts(11);
    wait_bm_low;
    bus.frame_abort = 1'b1;
    tick;
    bus.frame_abort = 1'b0;
    bad = 0;
    k = 0;
    while (bus.bm_done !== 1'b1 && k < 100) begin
      if (bus.frame_done) bad++;
      tick;
      k++;
    end
    chk("abort_early_done", 32'(bad), 0);
    chk("abort_done", 32'(bus.frame_done), 1);
    chk("abort_busy", 32'(bus.frame_busy), 0);
    tick;
    chk("abort_done_pulse", 32'(bus.frame_done), 0);
    repeat (30) tick;
    chk("abort_starts", 32'(n_start), 11);
    chk("abort_done_count", 32'(n_done), 1);
    // reset mid-frame, then restart with new base
    hang_idx = 0;
    start_frame(16'd0, 16'd0);
    wait_starts(2);
    hang_idx = -1;
    wait_bm_low;
    reset_n = 1'b0;
    mdl_rst = 1'b1;
    tick;
    chk("mid_rst_start", 32'(bus.bm_start), 0);
    chk("mid_rst_busy", 32'(bus.frame_busy), 0);
    chk("mid_rst_err", 32'(bus.sched_err), 0);
    reset_n = 1'b1;
    start_frame(16'h1000, 16'd0);
    tick;
    chk("restart_blk", 32'(bus.blk_start_address), 32'h1000);
    chk("restart_idx", 32'(bus.blk_index), 0);
    chk("restart_err", 32'(bus.sched_err), 0);
    chk("restart_start", 32'(bus.bm_start), 1);
    wait_done;
    chk("restart_starts", 32'(n_start), 32);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
